// File: rtl/bcd_operand_entry_if.sv
// Button inputs and operand outputs of the BCD operand entry stage.
// The DUT uses the slave view; the board or bench drives through the master view.
interface bcd_operand_entry_if;
    logic       KEY_INC;
    logic       KEY_NEXT;
    logic       KEY_ENTER;
    logic [7:0] LEFT_BCD;
    logic [7:0] RIGHT_BCD;
    logic       OPERANDS_VALID;
    logic       EDIT_RIGHT;
    logic       CURSOR;
    logic [1:0] LEDG_STATE;

    modport master (
        output KEY_INC, KEY_NEXT, KEY_ENTER,
        input  LEFT_BCD, RIGHT_BCD, OPERANDS_VALID, EDIT_RIGHT, CURSOR, LEDG_STATE
    );

    modport slave (
        input  KEY_INC, KEY_NEXT, KEY_ENTER,
        output LEFT_BCD, RIGHT_BCD, OPERANDS_VALID, EDIT_RIGHT, CURSOR, LEDG_STATE
    );
endinterface

// File: rtl/bcd_operand_entry.sv
// Builds two 2-digit BCD operands from three debounced push buttons and
// presents them, with a valid flag, to the adder and the operand displays.
module bcd_operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input logic                CLOCK_50,
    input logic                RESET_N,
    bcd_operand_entry_if.slave bus
);
    localparam int unsigned NKEY    = 3;
    localparam int unsigned K_INC   = 0;
    localparam int unsigned K_NEXT  = 1;
    localparam int unsigned K_ENTER = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LEFT  = 2'b00,
        ST_RIGHT = 2'b01,
        ST_HOLD  = 2'b10,
        ST_BAD   = 2'b11
    } state_e;

    logic [NKEY-1:0] raw_c;
    logic [NKEY-1:0] press_c;
    logic [1:0]      flush_q;

    assign raw_c = {bus.KEY_ENTER, bus.KEY_NEXT, bus.KEY_INC};

    // Synchronizer pipe is meaningful only once it has refilled after reset.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) flush_q <= 2'b00;
        else          flush_q <= {flush_q[0], 1'b1};
    end

    for (genvar k = 0; k < int'(NKEY); k++) begin : g_key
        logic             sync1_q, sync2_q;
        logic             deb_q, deb_d;
        logic             armed_q, armed_d;
        logic             press_q, press_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // A key held across reset stays disarmed until it is seen released,
        // so its eventual debounced press is swallowed.
        always_comb begin
            deb_d   = deb_q;
            armed_d = armed_q;
            press_d = 1'b0;
            cnt_d   = '0;
            if (flush_q[1] && sync2_q) armed_d = 1'b1;
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_d   = sync2_q;
                    press_d = armed_q & ~sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                deb_q   <= 1'b1;
                armed_q <= 1'b0;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= raw_c[k];
                sync2_q <= sync1_q;
                deb_q   <= deb_d;
                armed_q <= armed_d;
                press_q <= press_d;
                cnt_q   <= cnt_d;
            end
        end

        assign press_c[k] = press_q;
    end

    function automatic logic [3:0] bump_digit(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [7:0] bump_operand(input logic [7:0] v, input logic ones);
        return ones ? {v[7:4], bump_digit(v[3:0])} : {bump_digit(v[7:4]), v[3:0]};
    endfunction

    state_e     st_q, st_d;
    logic [7:0] left_q, left_d;
    logic [7:0] right_q, right_d;
    logic       valid_q, valid_d;
    logic       edit_q, edit_d;
    logic       cur_q, cur_d;

    // Operand FSM; ENTER outranks NEXT, which outranks INC.
    always_comb begin
        st_d    = st_q;
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        edit_d  = edit_q;
        cur_d   = cur_q;
        case (st_q)
            ST_LEFT: begin
                if (press_c[K_ENTER]) begin
                    st_d   = ST_RIGHT;
                    cur_d  = 1'b0;
                    edit_d = 1'b1;
                end else if (press_c[K_NEXT]) begin
                    cur_d = ~cur_q;
                end else if (press_c[K_INC]) begin
                    left_d = bump_operand(left_q, cur_q);
                end
            end
            ST_RIGHT: begin
                if (press_c[K_ENTER]) begin
                    st_d    = ST_HOLD;
                    valid_d = 1'b1;
                    cur_d   = 1'b0;
                end else if (press_c[K_NEXT]) begin
                    cur_d = ~cur_q;
                end else if (press_c[K_INC]) begin
                    right_d = bump_operand(right_q, cur_q);
                end
            end
            ST_HOLD: begin
                if (press_c[K_ENTER]) begin
                    st_d    = ST_LEFT;
                    left_d  = 8'h00;
                    right_d = 8'h00;
                    valid_d = 1'b0;
                    edit_d  = 1'b0;
                    cur_d   = 1'b0;
                end
            end
            default: begin
                st_d    = ST_LEFT;
                left_d  = 8'h00;
                right_d = 8'h00;
                valid_d = 1'b0;
                edit_d  = 1'b0;
                cur_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q    <= ST_LEFT;
            left_q  <= 8'h00;
            right_q <= 8'h00;
            valid_q <= 1'b0;
            edit_q  <= 1'b0;
            cur_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            edit_q  <= edit_d;
            cur_q   <= cur_d;
        end
    end

    assign bus.LEFT_BCD       = left_q;
    assign bus.RIGHT_BCD      = right_q;
    assign bus.OPERANDS_VALID = valid_q;
    assign bus.EDIT_RIGHT     = edit_q;
    assign bus.CURSOR         = cur_q;
    assign bus.LEDG_STATE     = st_q;
endmodule

// File: doc/bcd_operand_entry.md
Name: bcd_operand_entry

Overview:
- Upstream stage of the 2-digit BCD adder path. Builds the left and right 2-digit BCD operands from three push buttons.
- Debounces the buttons, runs a digit cursor and an operand state machine, then presents both operands with a valid flag.
- Downstream consumers are the adder (operands) and the operand 7-segment digits (HEX7..HEX4).

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a button level is accepted (1 ms at 50 MHz). Minimum 2.
- CNT_W, 16, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- KEY_INC  input  1  raw push button, active-low, asynchronous. Increments the digit under the cursor.
- KEY_NEXT  input  1  raw push button, active-low. Toggles the cursor between tens and ones.
- KEY_ENTER  input  1  raw push button, active-low. Commits the current operand, or clears from HOLD.
- LEFT_BCD  output  8  [7:4] tens, [3:0] ones of the left operand.
- RIGHT_BCD  output  8  [7:4] tens, [3:0] ones of the right operand.
- OPERANDS_VALID  output  1  high while in HOLD; both operands are stable.
- EDIT_RIGHT  output  1  0 = left operand is being edited, 1 = right operand.
- CURSOR  output  1  0 = tens digit selected, 1 = ones digit selected.
- LEDG_STATE  output  2  state code: 00 ENTER_LEFT, 01 ENTER_RIGHT, 10 HOLD.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - LEFT_BCD = RIGHT_BCD = 8'h00.
  - OPERANDS_VALID = 0, EDIT_RIGHT = 0, CURSOR = 0, state = ENTER_LEFT, LEDG_STATE = 00.
  - Synchronizers and debounced levels are set to 1 (released); debounce counters are cleared.
  - Reset asserted mid-press: on release of reset, a still-held button does not produce a pulse until it has been released and pressed again.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - The debounced level changes only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce back clears the counter.
  - Press pulse: 1 cycle high on the debounced 1->0 transition. Release produces no pulse.
  - Latency from a clean raw edge to the pulse: 2 + DEBOUNCE_CYCLES cycles.
- Pulse priority, when several pulses occur in one cycle: ENTER > NEXT > INC. Lower-priority pulses in that cycle are discarded.
- Digit increment:
  - The selected 4-bit digit goes 0..8 -> +1 and 9 -> 0.
  - No carry into the other digit.
  - A digit that is invalid (>9) is forced to 0 on increment. This is defensive; it cannot occur from reset.
- State machine (registered, updates on the clock edge following the pulse):
  - ENTER_LEFT:
    - INC updates LEFT_BCD at the cursor.
    - NEXT toggles CURSOR.
    - ENTER -> ENTER_RIGHT, with CURSOR = 0 and EDIT_RIGHT = 1.
  - ENTER_RIGHT:
    - INC and NEXT act on RIGHT_BCD.
    - ENTER -> HOLD, with OPERANDS_VALID = 1 and CURSOR = 0.
  - HOLD:
    - INC and NEXT are ignored; the operands are frozen.
    - ENTER -> ENTER_LEFT, with LEFT_BCD = RIGHT_BCD = 00, OPERANDS_VALID = 0, EDIT_RIGHT = 0 and CURSOR = 0, all in the same cycle.
  - Illegal state code 11 -> ENTER_LEFT with the reset values applied.
- OPERANDS_VALID goes high on the same edge the state enters HOLD and low on the same edge it leaves.
- All outputs are registered; there are no combinational paths from the KEY inputs to the outputs.
- A held button produces exactly one pulse. There is no auto-repeat.

Test Plan (DEBOUNCE_CYCLES = 4 in simulation):
- Reset then idle -> LEFT_BCD = 00, RIGHT_BCD = 00, OPERANDS_VALID = 0, LEDG_STATE = 00.
- KEY_INC pulsed low for 3 cycles (a bounce) then high -> no change. Held low for 10 cycles -> exactly one increment; LEFT_BCD = 8'h10 (cursor on tens).
- Cursor on tens, 10 clean INC presses -> tens digit sequences 1..9 and wraps back to 0. Then NEXT followed by 3 INC -> LEFT_BCD = 8'h03.
- Enter left = 8'h47 (4 INC, NEXT, 7 INC), ENTER, right = 8'h25, ENTER:
  - LEFT_BCD = 47, RIGHT_BCD = 25, OPERANDS_VALID = 1, LEDG_STATE = 10.
  - Further INC presses leave both operands unchanged.
- In HOLD, press ENTER -> both operands 00, OPERANDS_VALID = 0, state ENTER_LEFT, CURSOR = 0.
- Edge cases:
  - INC and ENTER debounced in the same cycle while in ENTER_LEFT -> state ENTER_RIGHT and LEFT_BCD unchanged.
  - RESET_N asserted while KEY_INC is held -> outputs clear immediately; no increment occurs after reset releases until a new press.
